// File: rtl/multicycle_alu_pkg.sv
// Shared opcode map and FSM state encoding for multicycle_alu.
// MULTICYCLE_ALU_DIV_EN adds the DIV state.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_DIV  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1
`ifdef MULTICYCLE_ALU_DIV_EN
    ,
    DIV  = 2'd2
`endif
  } state_e;

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the control unit (master) and multicycle_alu (slave).
interface multicycle_alu_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             overflow;

  modport master (
    output start, op, a, b,
    input  ready, done, result, result_hi, zero, overflow
  );

  modport slave (
    input  start, op, a, b,
    output ready, done, result, result_hi, zero, overflow
  );
endinterface

// File: rtl/multicycle_alu_core.sv
// Combinational single-cycle ALU ops; legal_c_o=0 for anything this core does not execute.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_c_o,
  output logic             overflow_c_o,
  output logic             legal_c_o
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH:0] sum_x;
  logic [WIDTH:0] diff_x;
  logic           ovf_add;
  logic           ovf_sub;
  logic           slt;

  // Overflow = carry into MSB xor carry out of MSB; SUB is a + ~b + 1.
  assign sum_x   = {1'b0, a_i} + {1'b0, b_i};
  assign diff_x  = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH+1)'(1);
  assign ovf_add = sum_x[WIDTH]  ^ (sum_x[MSB]  ^ a_i[MSB] ^ b_i[MSB]);
  assign ovf_sub = diff_x[WIDTH] ^ (diff_x[MSB] ^ a_i[MSB] ^ ~b_i[MSB]);
  assign slt     = diff_x[MSB] ^ ovf_sub;

  always_comb begin
    result_c_o   = '0;
    overflow_c_o = 1'b0;
    legal_c_o    = 1'b1;
    case (op_i)
      OP_AND:  result_c_o = a_i & b_i;
      OP_OR:   result_c_o = a_i | b_i;
      OP_ADD: begin
        result_c_o   = WIDTH'(sum_x);
        overflow_c_o = ovf_add;
      end
      OP_SUB: begin
        result_c_o   = WIDTH'(diff_x);
        overflow_c_o = ovf_sub;
      end
      OP_SLT:  result_c_o = WIDTH'(slt);
      OP_NOR:  result_c_o = ~a_i & ~b_i;
      OP_NAND: result_c_o = ~a_i | ~b_i;
      default: legal_c_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_alu.sv
// Registered ALU with start/done handshake and WIDTH-cycle shift-add multiply.
// MULTICYCLE_ALU_DIV_EN adds a WIDTH-cycle restoring divide on opcode 1011.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_alu_if.slave         bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic               zero_q, zero_d;
  logic               overflow_q, overflow_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]   core_result;
  logic               core_ovf;
  logic               core_legal;
  logic               last_iter;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_n;
  logic [WIDTH-1:0]   mul_lo_n;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op_i         (bus.op),
    .a_i          (bus.a),
    .b_i          (bus.b),
    .result_c_o   (core_result),
    .overflow_c_o (core_ovf),
    .legal_c_o    (core_legal)
  );

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // Shift-add step: {hi,lo} holds partial product in hi and remaining multiplier in lo.
  assign mul_sum              = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign {mul_hi_n, mul_lo_n} = {mul_sum, lo_q[WIDTH-1:1]};

`ifdef MULTICYCLE_ALU_DIV_EN
  logic               dbz_q, dbz_d;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_hi_n;
  logic [WIDTH-1:0]   div_lo_n;

  // Restoring step: hi is the partial remainder, lo shifts dividend out and quotient in.
  assign rem_sh   = {hi_q, lo_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, opnd_q};
  assign div_ge   = (rem_sh >= {1'b0, opnd_q});
  assign div_hi_n = div_ge ? WIDTH'(rem_diff) : WIDTH'(rem_sh);
  assign div_lo_n = {lo_q[WIDTH-2:0], div_ge};
`endif

  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    opnd_d      = opnd_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
`ifdef MULTICYCLE_ALU_DIV_EN
    dbz_d       = dbz_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MUL) begin
            state_d = MUL;
            opnd_d  = bus.a;
            hi_d    = '0;
            lo_d    = bus.b;
            cnt_d   = '0;
          end
`ifdef MULTICYCLE_ALU_DIV_EN
          else if (bus.op == OP_DIV) begin
            state_d = DIV;
            opnd_d  = bus.b;
            hi_d    = '0;
            lo_d    = bus.a;
            cnt_d   = '0;
            dbz_d   = (bus.b == '0);
          end
`endif
          else begin
            done_d      = 1'b1;
            result_hi_d = '0;
            if (core_legal) begin
              result_d   = core_result;
              zero_d     = (core_result == '0);
              overflow_d = core_ovf;
            end else begin
              result_d   = '0;
              zero_d     = 1'b1;
              overflow_d = 1'b0;
            end
          end
        end
      end

      MUL: begin
        hi_d  = mul_hi_n;
        lo_d  = mul_lo_n;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          result_d    = mul_lo_n;
          result_hi_d = mul_hi_n;
          zero_d      = (mul_lo_n == '0);
          overflow_d  = (mul_hi_n != '0);
        end
      end

`ifdef MULTICYCLE_ALU_DIV_EN
      DIV: begin
        hi_d  = div_hi_n;
        lo_d  = div_lo_n;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          result_d    = div_lo_n;
          result_hi_d = div_hi_n;
          zero_d      = (div_lo_n == '0);
          overflow_d  = dbz_q;
        end
      end
`endif

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      opnd_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
`ifdef MULTICYCLE_ALU_DIV_EN
      dbz_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      opnd_q      <= opnd_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
`ifdef MULTICYCLE_ALU_DIV_EN
      dbz_q       <= dbz_d;
`endif
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;

endmodule
